// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux selects,
// ALU commands and condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  localparam logic [1:0] ImmDp     = 2'b00;
  localparam logic [1:0] ImmMem    = 2'b01;
  localparam logic [1:0] ImmBranch = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  localparam logic [1:0] SrcAReg = 2'b00;
  localparam logic [1:0] SrcAPc  = 2'b01;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;

  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdCmp = 4'b1010;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition-code evaluation: Cond field against the architectural NZCV register.
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge, hi, gt;

  assign {n, z, c, v} = flags;
  assign ge = (n == v);
  assign hi = c & ~z;
  assign gt = ~z & ge;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      CondEq:  cond_ex = z;
      CondNe:  cond_ex = ~z;
      CondCs:  cond_ex = c;
      CondCc:  cond_ex = ~c;
      CondMi:  cond_ex = n;
      CondPl:  cond_ex = ~n;
      CondVs:  cond_ex = v;
      CondVc:  cond_ex = ~v;
      CondHi:  cond_ex = hi;
      CondLs:  cond_ex = ~hi;
      CondGe:  cond_ex = ge;
      CondLt:  cond_ex = ~ge;
      CondGt:  cond_ex = gt;
      CondLe:  cond_ex = ~gt;
      CondAl:  cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle ARM-subset datapath; owns the NZCV register.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic [1:0] alu_dec;
  logic       cond_ex, cmd_valid, is_cmp, is_logic, rd_pc, in_exec, alu_wb;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^Instr[7:4];

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    alu_dec   = AluAdd;
    cmd_valid = 1'b1;
    case (cmd)
      CmdAdd:  alu_dec = AluAdd;
      CmdSub:  alu_dec = AluSub;
      CmdAnd:  alu_dec = AluAnd;
      CmdOrr:  alu_dec = AluOrr;
      CmdCmp:  alu_dec = AluSub;
      default: cmd_valid = 1'b0;
    endcase
  end

  assign is_cmp   = (cmd == CmdCmp);
  assign is_logic = (cmd == CmdAnd) || (cmd == CmdOrr);
  assign rd_pc    = (rd == 4'hF);
  assign in_exec  = (state_q == StExecR) || (state_q == StExecI);
  // CMP and unknown commands never write back, whatever the condition says.
  assign alu_wb   = cond_ex & cmd_valid & ~is_cmp;

  always_comb begin
    flags_d = flags_q;
    if (in_exec && cmd_valid && (funct[0] || is_cmp) && cond_ex) begin
      flags_d = is_logic ? {ALUFlags[3:2], flags_q[1:0]} : ALUFlags;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpMem:    state_d = StMemAdr;
          OpDp:     state_d = funct[5] ? StExecI : StExecR;
          OpBranch: state_d = StBranch;
          default:  state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ImmSrc     = ImmDp;
    ALUSrcA    = SrcAReg;
    ALUSrcB    = SrcBReg;
    ResultSrc  = ResAluOut;
    ALUControl = AluAdd;
    case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAlu;
      end
      StDecode: begin
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAlu;
      end
      StMemAdr: begin
        ALUSrcB = SrcBImm;
        ImmSrc  = ImmMem;
      end
      StMemRd: AdrSrc = 1'b1;
      StMemWr: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      StMemWb: begin
        ResultSrc = ResMem;
        PCWrite   = cond_ex & rd_pc;
        RegWrite  = cond_ex & ~rd_pc;
      end
      StExecR: ALUControl = alu_dec;
      StExecI: begin
        ALUSrcB    = SrcBImm;
        ALUControl = alu_dec;
      end
      StAluWb: begin
        PCWrite  = alu_wb & rd_pc;
        RegWrite = alu_wb & ~rd_pc;
      end
      StBranch: begin
        ALUSrcB   = SrcBImm;
        ImmSrc    = ImmBranch;
        ResultSrc = ResAlu;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
  end

  assign RegSrc = {op == OpMem, op == OpBranch};
  assign Flags  = flags_q;
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller with a per-cycle expectation queue.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl;
  logic [3:0]  Flags, State;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .State      (State)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string           nm;
    logic [19:0]     instr;
    logic [3:0]      aluf;
    int              n;
    logic [4:0][3:0] st;
    logic [4:0]      rw, pw, mw;
    logic [1:0]      alu;
    logic [3:0]      fl;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    logic       ir, pw, rw, mw;
  } cyc_t;

  cyc_t sb[$];
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] ins(logic [3:0] cd, logic [1:0] op, logic [5:0] f,
                                      logic [3:0] rd);
    return {cd, op, f, 4'h0, rd};
  endfunction

  function automatic vec_t mkv(string nm, logic [19:0] instr, logic [3:0] aluf, int n,
                               state_e s0, state_e s1, state_e s2, state_e s3, state_e s4,
                               logic [4:0] rw, logic [4:0] pw, logic [4:0] mw,
                               logic [1:0] alu, logic [3:0] fl);
    vec_t v;
    v.nm = nm; v.instr = instr; v.aluf = aluf; v.n = n;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
    v.rw = rw; v.pw = pw; v.mw = mw; v.alu = alu; v.fl = fl;
    return v;
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves at the next FETCH.
  task automatic run_vec(input vec_t v);
    cyc_t e;
    Instr    = v.instr;
    ALUFlags = v.aluf;
    for (int c = 0; c < v.n; c++) begin
      sb.push_back('{st: v.st[c], ir: (c == 0), pw: v.pw[c], rw: v.rw[c], mw: v.mw[c]});
    end
    for (int c = 0; c < v.n; c++) begin
      #1;
      if (sb.size() == 0) begin
        check({v.nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_c%0d_state", v.nm, c), State, e.st);
        check($sformatf("%s_c%0d_irw", v.nm, c), IRWrite, e.ir);
        check($sformatf("%s_c%0d_pcw", v.nm, c), PCWrite, e.pw);
        check($sformatf("%s_c%0d_regw", v.nm, c), RegWrite, e.rw);
        check($sformatf("%s_c%0d_memw", v.nm, c), MemWrite, e.mw);
      end
      if (c == 2) check({v.nm, "_aluctl"}, ALUControl, v.alu);
      if (c == v.n - 1) check({v.nm, "_flags"}, Flags, v.fl);
      @(negedge clk);
    end
  endtask

  // Structural invariants, checked every cycle out of reset.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        check("mw_rw_exclusive", {31'd0, MemWrite & RegWrite}, 32'd0);
        if (State != StFetch && State != StBranch && State != StAluWb && State != StMemWb)
          check("pcw_outside_allowed", {31'd0, PCWrite}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    localparam logic [3:0] Al = 4'hE;
    vecs.push_back(mkv("str_eq_fail", ins(4'h0, 2'b01, 6'b011000, 4'd4), 4'h0, 4,
                       StFetch, StDecode, StMemAdr, StMemWr, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluAdd, 4'h0));
    vecs.push_back(mkv("str_al", ins(Al, 2'b01, 6'b011000, 4'd4), 4'h0, 4,
                       StFetch, StDecode, StMemAdr, StMemWr, StFetch,
                       5'b00000, 5'b00001, 5'b01000, AluAdd, 4'h0));
    vecs.push_back(mkv("adds_r1", ins(Al, 2'b00, 6'b101001, 4'd1), 4'h6, 4,
                       StFetch, StDecode, StExecI, StAluWb, StFetch,
                       5'b01000, 5'b00001, 5'b00000, AluAdd, 4'h6));
    vecs.push_back(mkv("ldr_r2", ins(Al, 2'b01, 6'b011001, 4'd2), 4'hF, 5,
                       StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
                       5'b10000, 5'b00001, 5'b00000, AluAdd, 4'h6));
    vecs.push_back(mkv("ldr_pc", ins(Al, 2'b01, 6'b011001, 4'd15), 4'h0, 5,
                       StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
                       5'b00000, 5'b10001, 5'b00000, AluAdd, 4'h6));
    vecs.push_back(mkv("cmp_z", ins(Al, 2'b00, 6'b010101, 4'd0), 4'h4, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluSub, 4'h4));
    vecs.push_back(mkv("bne_taken_no", ins(4'h1, 2'b10, 6'b100000, 4'd0), 4'h0, 3,
                       StFetch, StDecode, StBranch, StFetch, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluAdd, 4'h4));
    vecs.push_back(mkv("cmp_nz", ins(Al, 2'b00, 6'b010101, 4'd0), 4'h0, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluSub, 4'h0));
    vecs.push_back(mkv("bne_taken", ins(4'h1, 2'b10, 6'b100000, 4'd0), 4'h0, 3,
                       StFetch, StDecode, StBranch, StFetch, StFetch,
                       5'b00000, 5'b00101, 5'b00000, AluAdd, 4'h0));
    vecs.push_back(mkv("ands_r3", ins(Al, 2'b00, 6'b000001, 4'd3), 4'hB, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b01000, 5'b00001, 5'b00000, AluAnd, 4'h8));
    vecs.push_back(mkv("orr_pc", ins(Al, 2'b00, 6'b011000, 4'd15), 4'hF, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b00000, 5'b01001, 5'b00000, AluOrr, 4'h8));
    vecs.push_back(mkv("nop", ins(Al, 2'b11, 6'b000000, 4'd0), 4'hF, 2,
                       StFetch, StDecode, StFetch, StFetch, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluAdd, 4'h8));
    vecs.push_back(mkv("subeq_fail", ins(4'h0, 2'b00, 6'b000100, 4'd5), 4'hF, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluSub, 4'h8));
    vecs.push_back(mkv("addsne", ins(4'h1, 2'b00, 6'b101001, 4'd6), 4'h3, 4,
                       StFetch, StDecode, StExecI, StAluWb, StFetch,
                       5'b01000, 5'b00001, 5'b00000, AluAdd, 4'h3));
    vecs.push_back(mkv("addgt_fail", ins(4'hC, 2'b00, 6'b001000, 4'd4), 4'h0, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluAdd, 4'h3));
    vecs.push_back(mkv("addlt", ins(4'hB, 2'b00, 6'b001000, 4'd4), 4'h0, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b01000, 5'b00001, 5'b00000, AluAdd, 4'h3));
    vecs.push_back(mkv("beq_fail", ins(4'h0, 2'b10, 6'b100000, 4'd0), 4'h0, 3,
                       StFetch, StDecode, StBranch, StFetch, StFetch,
                       5'b00000, 5'b00001, 5'b00000, AluAdd, 4'h3));
    vecs.push_back(mkv("andsi", ins(Al, 2'b00, 6'b100001, 4'd7), 4'h4, 4,
                       StFetch, StDecode, StExecI, StAluWb, StFetch,
                       5'b01000, 5'b00001, 5'b00000, AluAnd, 4'h7));
    vecs.push_back(mkv("orrs", ins(Al, 2'b00, 6'b011001, 4'd8), 4'h8, 4,
                       StFetch, StDecode, StExecR, StAluWb, StFetch,
                       5'b01000, 5'b00001, 5'b00000, AluOrr, 4'hB));

    // Reset state, then release mid-cycle.
    #1;
    check("rst_state", State, StFetch);
    check("rst_flags", Flags, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // LDR datapath selects, cycle by cycle.
    Instr = ins(4'hE, 2'b01, 6'b011001, 4'd2);
    #1;
    check("ldr_fetch_srca", ALUSrcA, SrcAPc);
    check("ldr_fetch_srcb", ALUSrcB, SrcBFour);
    check("ldr_fetch_res", ResultSrc, ResAlu);
    check("ldr_fetch_adr", AdrSrc, 1'b0);
    @(negedge clk); #1;
    check("ldr_dec_state", State, StDecode);
    check("ldr_regsrc", RegSrc, 2'b10);
    @(negedge clk); #1;
    check("ldr_madr_srcb", ALUSrcB, SrcBImm);
    check("ldr_madr_imm", ImmSrc, ImmMem);
    @(negedge clk); #1;
    check("ldr_mrd_state", State, StMemRd);
    check("ldr_mrd_adr", AdrSrc, 1'b1);
    @(negedge clk); #1;
    check("ldr_mwb_res", ResultSrc, ResMem);
    check("ldr_mwb_regw", RegWrite, 1'b1);
    @(negedge clk);

    // Asynchronous reset in the middle of an LDR's MEMRD cycle.
    repeat (3) @(negedge clk);
    #1;
    check("mid_state_memrd", State, StMemRd);
    check("pre_rst_flags", Flags, 4'hB);
    reset = 1'b1;
    #1;
    check("async_rst_state", State, StFetch);
    check("async_rst_flags", Flags, 4'h0);
    check("async_rst_regw", RegWrite, 1'b0);
    @(posedge clk); #1;
    check("held_rst_state", State, StFetch);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_irw", IRWrite, 1'b1);
    check("post_rst_pcw", PCWrite, 1'b1);
    @(negedge clk);
    rv = mkv("ldr_after_rst", ins(4'hE, 2'b01, 6'b011001, 4'd2), 4'h0, 5,
             StDecode, StMemAdr, StMemRd, StMemWb, StFetch,
             5'b01000, 5'b00000, 5'b00000, AluAdd, 4'h0);
    // Starts at DECODE here, so IRWrite is not expected in its first slot.
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("post_rst_c%0d_state", c), State, rv.st[c]);
      check($sformatf("post_rst_c%0d_regw", c), RegWrite, rv.rw[c]);
      check($sformatf("post_rst_c%0d_irw", c), IRWrite, 1'b0);
      @(negedge clk);
    end
    #1;
    check("post_rst_refetch", State, StFetch);
    check("post_rst_flags", Flags, rv.fl);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle version of the ARM-subset processor. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It issues the per-cycle enables and mux selects to the shared-memory multicycle datapath, and owns the NZCV flag register and condition-code evaluation. It sits beside the datapath in the processor top and replaces the single-cycle combinational decoder.

## Interface
Parameters: none; encodings live in the shared package.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Instr  in  20  latched instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  NZCV from the datapath ALU, current cycle
- PCWrite  out  1  load PC
- IRWrite  out  1  load instruction register
- MemWrite  out  1  data-memory write strobe
- RegWrite  out  1  register-file write enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- RegSrc  out  2  [0] RA1=R15, [1] RA2=Rd
- ImmSrc  out  2  extend mode: 00 imm8, 01 imm12, 10 imm24 branch
- ALUSrcA  out  2  00 register A, 01 PC
- ALUSrcB  out  2  00 register B, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Flags  out  4  architectural NZCV register
- State  out  4  current FSM state (debug)

## Operation
- States are FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=00: Funct[5]=0 → EXECR; Funct[5]=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11 → FETCH (NOP).
  - MEMADR: Funct[0]=1 → MEMRD; Funct[0]=0 → MEMWR.
  - MEMRD→MEMWB.
  - EXECR/EXECI→ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
  - An illegal state encoding → FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, PCWrite=1. This is PC+4.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Produces PC+8 for R15 reads.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ImmSrc=01, ALUControl=ADD.
- MEMRD: AdrSrc=1. MEMWR: AdrSrc=1, MemWrite=CondEx. MEMWB: ResultSrc=01.
- EXECR/EXECI:
  - ALUSrcB=00 (EXECR) or 01 with ImmSrc=00 (EXECI).
  - ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP→SUB.
  - Any other cmd → ADD with writeback suppressed.
- ALUWB: ResultSrc=00.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ImmSrc=10, ResultSrc=10, ALUControl=ADD, PCWrite=CondEx.
- Writeback in MEMWB/ALUWB:
  - Rd≠15: RegWrite=CondEx.
  - Rd=15: RegWrite=0, PCWrite=CondEx.
  - CMP never writes back.
- CondEx is combinational from Cond and the Flags register:
  - EQ/NE: Z.
  - CS/CC: C.
  - MI/PL: N.
  - VS/VC: V.
  - HI: C&~Z. LS: the complement of HI.
  - GE: N==V. LT: N≠V.
  - GT: ~Z&(N==V). LE: the complement of GT.
  - AL=1.
  - 1111 → 0.
- Flag update happens on the clock edge leaving EXECR/EXECI, only if Funct[0]=1 (or CMP) and CondEx:
  - ADD/SUB/CMP load NZCV.
  - AND/ORR load NZ only; CV are held.
- A failed condition never suppresses the FETCH-state PCWrite or IRWrite.

## Timing
- Reset (async, immediate):
  - State=FETCH, Flags=0000.
  - After release, the FETCH strobes IRWrite=1 and PCWrite=1 are asserted in the first cycle.
  - While reset is held, State is forced to FETCH; a reset mid-instruction discards it with no partial write.
- All outputs are decoded from State, latched Instr and Flags only; no ALUFlags→output path.
- Instruction cycle counts: branch 3, data-processing 4, STR 4, LDR 5, NOP (Op=11) 2.
- ALUFlags are sampled only on the EXECR/EXECI exit edge. Flags become visible to CondEx from the next cycle, which is always ALUWB. Back-to-back flag-set then conditional instruction therefore needs no stall.
- At most one of MemWrite/RegWrite is asserted in any cycle.
- PCWrite outside FETCH occurs only in BRANCH, ALUWB or MEMWB.

## Structure
- Package `mc_pkg`:
  - state enum (4-bit);
  - ALUControl, ImmSrc, ResultSrc and ALUSrcB encodings;
  - Op and cmd constants;
  - condition-code constants.
- Sub-module `cond_check`: combinational Cond + NZCV → CondEx.
- FSM next-state logic, output decode and flag register stay in this block.

## Test plan
- Reset pulsed mid-MEMRD → State=FETCH and Flags=0000 immediately; no RegWrite after release; first cycle shows IRWrite=1, PCWrite=1.
- ADDS R1 (Cond=1110, Op=00, Funct=101001), ALUFlags=0110 in EXECI → states FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in ALUWB only; Flags=0110 afterwards.
- LDR Rd=2 (Op=01, Funct[0]=1) → 5 cycles; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR with Cond=0000 (EQ) and Flags=0000 → MEMWR visited with MemWrite=0; next FETCH follows normally.
- CMP (Funct=010101) giving ALUFlags=0100, then BNE → BRANCH has PCWrite=0; with ALUFlags=0000 instead, PCWrite=1.
- ANDS with ALUFlags=1011, prior Flags=0000 → Flags=1000 (CV held). ORR Rd=15, Cond=AL → ALUWB has PCWrite=1, RegWrite=0.
